// File: rtl/spi_arb_pkg.sv
// rtl/spi_arb_pkg.sv - shared types and helpers for the spi_master arbiter
// Purpose: FSM state encoding, requester-count bounds, round-robin pointer helper.
// Ports: none (package).
package spi_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WAIT   = 3'd2,
    ST_DONE   = 3'd3,
    ST_GAP    = 3'd4
  } state_t;

  localparam int NREQ_MIN = 2;
  localparam int NREQ_MAX = 8;

  // Clamp a requested client count into the supported range so an illegal
  // parameter degrades to a legal arbiter instead of producing zero-width buses.
  function automatic int nreq_clamp(input int n);
    if (n < NREQ_MIN) return NREQ_MIN;
    if (n > NREQ_MAX) return NREQ_MAX;
    return n;
  endfunction

  // Pointer position just past the last winner, wrapping at n-1 -> 0.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin winner selection
// Purpose: pick the first set request scanning upward from rr_ptr, wrapping.
// Ports: req (requests), rr_ptr (scan start), onehot (winner one-hot),
//        idx (winner index), any (at least one request set).
module rr_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rr_ptr,
  output logic [NREQ-1:0] onehot,
  output logic [IW-1:0]   idx,
  output logic            any
);

  always_comb begin
    int p;
    p      = 0;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    // Scan from the farthest offset back to rr_ptr so the closest set bit
    // is the last one written and therefore wins.
    for (int off = NREQ - 1; off >= 0; off--) begin
      p = (int'(rr_ptr) + off) % NREQ;
      if (req[p]) begin
        onehot    = '0;
        onehot[p] = 1'b1;
        idx       = IW'(p);
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_master_arbiter.sv
// rtl/spi_master_arbiter.sv - round-robin sharing of one spi_master among NREQ clients
// Purpose: grant one client, launch its transfer, wait for finish or watchdog, return data.
// Ports: clk/rst (sync active-low); req/req_mode/req_clkdiv/req_data from clients;
//        grant/done/err/rdata/cs_sel to clients and slave-select steering;
//        m_start/m_mode/m_clkdiv/m_data to spi_master; m_finish/m_rdata from it.
module spi_master_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int GAP     = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [2*NREQ-1:0] req_mode,
  input  logic [2*NREQ-1:0] req_clkdiv,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic              err,
  output logic [7:0]        rdata,
  output logic [NREQ-1:0]   cs_sel,
  output logic              m_start,
  output logic [1:0]        m_mode,
  output logic [1:0]        m_clkdiv,
  output logic [7:0]        m_data,
  input  logic              m_finish,
  input  logic [7:0]        m_rdata
);

  localparam int NQ   = nreq_clamp(NREQ);
  localparam int IW   = $clog2(NQ);
  // One counter serves both the watchdog and the post-transfer gap.
  localparam int CMAX = (TIMEOUT > GAP) ? TIMEOUT : GAP;
  localparam int CW   = $clog2(CMAX + 1);

  state_t          state;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   owner;
  logic [CW-1:0]   cnt;

  logic [NREQ-1:0] win_oh;
  logic [IW-1:0]   win_idx;
  logic            win_any;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req    (req),
    .rr_ptr (rr_ptr),
    .onehot (win_oh),
    .idx    (win_idx),
    .any    (win_any)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      cnt      <= '0;
      grant    <= '0;
      done     <= '0;
      err      <= 1'b0;
      rdata    <= '0;
      cs_sel   <= '0;
      m_start  <= 1'b0;
      m_mode   <= '0;
      m_clkdiv <= '0;
      m_data   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (win_any) begin
            owner    <= win_idx;
            grant    <= win_oh;
            cs_sel   <= win_oh;
            m_mode   <= req_mode[2*int'(win_idx) +: 2];
            m_clkdiv <= req_clkdiv[2*int'(win_idx) +: 2];
            m_data   <= req_data[8*int'(win_idx) +: 8];
            m_start  <= 1'b1;
            state    <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          m_start <= 1'b0;
          cnt     <= '0;
          state   <= ST_WAIT;
        end
        ST_WAIT: begin
          // A finish arriving on the expiry cycle still counts as success.
          if (m_finish) begin
            rdata <= m_rdata;
            done  <= grant;
            err   <= 1'b0;
            state <= ST_DONE;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            rdata <= '0;
            done  <= grant;
            err   <= 1'b1;
            state <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          rr_ptr <= IW'(rr_next(int'(owner), NQ));
          grant  <= '0;
          cs_sel <= '0;
          done   <= '0;
          err    <= 1'b0;
          cnt    <= '0;
          state  <= (GAP > 0) ? ST_GAP : ST_IDLE;
        end
        ST_GAP: begin
          if (cnt == CW'(GAP - 1)) state <= ST_IDLE;
          else                     cnt   <= cnt + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_arbiter.sv
// tb/tb_spi_master_arbiter.sv - self-checking bench for spi_master_arbiter
module tb_spi_master_arbiter;

  localparam int NREQ    = 4;
  localparam int GAP     = 2;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [2*NREQ-1:0] req_mode;
  logic [2*NREQ-1:0] req_clkdiv;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   done;
  logic              err;
  logic [7:0]        rdata;
  logic [NREQ-1:0]   cs_sel;
  logic              m_start;
  logic [1:0]        m_mode;
  logic [1:0]        m_clkdiv;
  logic [7:0]        m_data;
  logic              m_finish;
  logic [7:0]        m_rdata;

  spi_master_arbiter #(.NREQ(NREQ), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_mode   (req_mode),
    .req_clkdiv (req_clkdiv),
    .req_data   (req_data),
    .grant      (grant),
    .done       (done),
    .err        (err),
    .rdata      (rdata),
    .cs_sel     (cs_sel),
    .m_start    (m_start),
    .m_mode     (m_mode),
    .m_clkdiv   (m_clkdiv),
    .m_data     (m_data),
    .m_finish   (m_finish),
    .m_rdata    (m_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NREQ-1:0] who;
    logic [7:0]      data;
    logic            err;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   start_cyc = 0;
  int   fin_delay = 0;
  logic [7:0] fin_byte = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (m_start) start_cyc <= cyc;

  // spi_master model: finish pulse fin_delay cycles after start (0 = never).
  initial begin
    m_finish = 1'b0;
    m_rdata  = 8'h00;
    forever begin
      @(negedge clk);
      if (m_start && fin_delay > 0) begin
        repeat (fin_delay) @(posedge clk);
        #1;
        m_finish = 1'b1;
        m_rdata  = fin_byte;
        @(posedge clk);
        #1;
        m_finish = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait for a done pulse, pop the scoreboard entry and compare; lat is start-to-done cycles.
  task automatic wait_done(input string tag, output int lat);
    int   n;
    exp_t e;
    n   = 0;
    lat = -1;
    do begin
      @(negedge clk);
      n++;
    end while (done === '0 && n < 2000);
    if (done === '0) begin
      check({tag, "_done_timeout"}, 32'(done), 32'hFFFF_FFFF);
    end else if (sb.size() == 0) begin
      check({tag, "_unexpected_done"}, 32'(done), 32'h0);
    end else begin
      e = sb.pop_front();
      check({tag, "_done"},  32'(done),  32'(e.who));
      check({tag, "_grant"}, 32'(grant), 32'(e.who));
      check({tag, "_rdata"}, 32'(rdata), 32'(e.data));
      check({tag, "_err"},   32'(err),   32'(e.err));
      lat = cyc - start_cyc;
    end
  endtask

  task automatic push(input logic [NREQ-1:0] who, input logic [7:0] data, input logic e);
    exp_t x;
    x.who  = who;
    x.data = data;
    x.err  = e;
    sb.push_back(x);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"},  32'(grant),    32'h0);
    check({tag, "_done"},   32'(done),     32'h0);
    check({tag, "_err"},    32'(err),      32'h0);
    check({tag, "_rdata"},  32'(rdata),    32'h0);
    check({tag, "_cs_sel"}, 32'(cs_sel),   32'h0);
    check({tag, "_start"},  32'(m_start),  32'h0);
    check({tag, "_mode"},   32'(m_mode),   32'h0);
    check({tag, "_clkdiv"}, 32'(m_clkdiv), 32'h0);
    check({tag, "_data"},   32'(m_data),   32'h0);
  endtask

  initial begin
    int lat;
    int n;
    rst        = 1'b0;
    req        = '0;
    req_mode   = '0;
    req_clkdiv = '0;
    req_data   = '0;

    // reset state
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;

    // reset in the middle of WAIT
    req_data[7:0]   = 8'h77;
    req_mode[1:0]   = 2'b11;
    req_clkdiv[1:0] = 2'b10;
    fin_delay = 0;
    req = 4'b0001;
    @(negedge clk);
    check("pre_rst_start", 32'(m_start), 32'h1);
    check("pre_rst_grant", 32'(grant),   32'h1);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    req = '0;
    @(negedge clk);
    check_all_zero("midwait_rst");
    rst = 1'b1;
    req_data[23:16] = 8'h11;
    fin_delay = 3;
    fin_byte  = 8'h3C;
    push(4'b0100, 8'h3C, 1'b0);
    req = 4'b0100;
    @(negedge clk);
    check("post_rst_grant",  32'(grant),  32'h4);
    check("post_rst_cs_sel", 32'(cs_sel), 32'h4);
    wait_done("post_rst", lat);
    check("post_rst_lat", 32'(lat), 32'd4);

    // wrap: pointer now 3, so 0101 goes to client 0, then client 2
    fin_byte = 8'h96;
    push(4'b0001, 8'h96, 1'b0);
    req = 4'b0101;
    wait_done("wrap0", lat);
    push(4'b0100, 8'h96, 1'b0);
    req = 4'b0100;
    wait_done("wrap2", lat);
    req = '0;

    // single requester with mode/data passthrough
    repeat (GAP + 1) @(negedge clk);
    req_data[15:8]  = 8'hDD;
    req_mode[3:2]   = 2'b01;
    req_clkdiv[3:2] = 2'b11;
    fin_delay = 2;
    fin_byte  = 8'hA5;
    push(4'b0010, 8'hA5, 1'b0);
    req = 4'b0010;
    @(negedge clk);
    check("single_start",  32'(m_start),  32'h1);
    check("single_data",   32'(m_data),   32'hDD);
    check("single_mode",   32'(m_mode),   32'h1);
    check("single_clkdiv", 32'(m_clkdiv), 32'h3);
    check("single_grant",  32'(grant),    32'h2);
    req_data[15:8] = 8'h00;
    @(negedge clk);
    check("single_start_pulse", 32'(m_start), 32'h0);
    check("single_cfg_held",    32'(m_data),  32'hDD);
    wait_done("single", lat);
    check("single_lat", 32'(lat), 32'd3);
    req = '0;
    @(negedge clk);
    check("single_done_pulse", 32'(done),  32'h0);
    check("single_rdata_held", 32'(rdata), 32'hA5);
    check("single_cfg_kept",   32'(m_data), 32'hDD);

    // fairness from a fresh pointer, with gap length checked between transfers
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    fin_delay = 2;
    fin_byte  = 8'hC3;
    for (int k = 0; k < 8; k++) push(4'(1 << (k % NREQ)), 8'hC3, 1'b0);
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      wait_done($sformatf("fair%0d", k), lat);
      if (k < 3) begin
        n = 0;
        for (int t = 0; t < 50 && !m_start; t++) begin
          @(negedge clk);
          if (grant === '0) n++;
        end
        check($sformatf("gap%0d", k), 32'(n), 32'(GAP + 1));
      end
    end
    req = '0;

    // watchdog expiry
    repeat (GAP + 1) @(negedge clk);
    fin_delay = 0;
    push(4'b0001, 8'h00, 1'b1);
    req = 4'b0001;
    wait_done("timeout", lat);
    check("timeout_lat", 32'(lat), 32'(TIMEOUT + 1));
    req = '0;

    // finish on the expiry cycle wins over the watchdog
    repeat (GAP + 1) @(negedge clk);
    fin_delay = TIMEOUT;
    fin_byte  = 8'h5A;
    push(4'b0010, 8'h5A, 1'b0);
    req = 4'b0010;
    wait_done("expiry_finish", lat);
    check("expiry_finish_lat", 32'(lat), 32'(TIMEOUT + 1));
    req = '0;

    check("sb_empty", 32'(sb.size()), 32'h0);
    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
